mem_arbiter: RTL and testbench

Parametrised N-channel memory-bus arbiter that shares one single-port synchronous RAM among several CPU-style masters. Each master uses a request/acknowledge handshake with address, write data and write enable. Each transaction is arbitrated round-robin and driven onto the RAM bus for one cycle; read data returns after the RAM's read latency. It sits between the cpu instance(s) and ram in the system and in cpu_tb.

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter sharing one single-port synchronous RAM among req/ack masters.
// Define MEM_ARB_FIXED_PRI_EN to switch to fixed priority (lowest channel wins).
module mem_arbiter #(
  parameter int NUM_CH = 4,
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    m_req,
  input  logic [NUM_CH-1:0]    m_we,
  input  logic [NUM_CH*AW-1:0] m_addr,
  input  logic [NUM_CH*DW-1:0] m_wdata,
  output logic [NUM_CH-1:0]    m_ack,
  output logic [DW-1:0]        m_rdata,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_do,
  output logic                 mem_we,
  input  logic [DW-1:0]        mem_di,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WAIT_INIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Handshake: a master holds m_req (with we/addr/wdata stable) until it sees
  // its one-cycle m_ack; requests are only sampled in IDLE, so a request still
  // high in the cycle after its ack is arbitrated again as a new transaction.
  state_t              state_q, state_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic                we_q, we_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_do_q, mem_do_d;
  logic                mem_we_q, mem_we_d;
  logic [NUM_CH-1:0]   m_ack_q, m_ack_d;
  logic [DW-1:0]       m_rdata_q, m_rdata_d;
  logic [CW-1:0]       grant_ch;
  logic                enter_done;
`ifndef MEM_ARB_FIXED_PRI_EN
  logic [CW-1:0]       last_grant_q, last_grant_d;
`endif

  always_comb begin
    grant_ch = '0;
`ifdef MEM_ARB_FIXED_PRI_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m_req[i]) grant_ch = CW'(i);
    end
`else
    // Descending offset so the channel closest after last_grant is assigned last.
    for (int k = NUM_CH; k >= 1; k--) begin
      if (m_req[(int'(last_grant_q) + k) % NUM_CH]) grant_ch = CW'((int'(last_grant_q) + k) % NUM_CH);
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_do_d   = mem_do_q;
    mem_we_d   = 1'b0;
    m_ack_d    = '0;
    m_rdata_d  = m_rdata_q;
    enter_done = 1'b0;
`ifndef MEM_ARB_FIXED_PRI_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|m_req) begin
          state_d    = S_ISSUE;
          ch_d       = grant_ch;
          we_d       = m_we[grant_ch];
          mem_addr_d = m_addr[int'(grant_ch)*AW +: AW];
          mem_do_d   = m_wdata[int'(grant_ch)*DW +: DW];
          mem_we_d   = m_we[grant_ch];
`ifndef MEM_ARB_FIXED_PRI_EN
          last_grant_d = grant_ch;
`endif
        end
      end
      S_ISSUE: begin
        if (we_q || RD_LAT == 1) begin
          enter_done = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 2'(WAIT_INIT);
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) enter_done = 1'b1;
        else cnt_d = cnt_q - 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // mem_di is captured on the edge entering DONE, RD_LAT edges after mem_addr was set.
    if (enter_done) begin
      state_d       = S_DONE;
      m_ack_d[ch_q] = 1'b1;
      if (!we_q) m_rdata_d = mem_di;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      we_q       <= 1'b0;
      cnt_q      <= 2'd0;
      mem_addr_q <= '0;
      mem_do_q   <= '0;
      mem_we_q   <= 1'b0;
      m_ack_q    <= '0;
      m_rdata_q  <= '0;
`ifndef MEM_ARB_FIXED_PRI_EN
      last_grant_q <= CW'(NUM_CH - 1);
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_do_q   <= mem_do_d;
      mem_we_q   <= mem_we_d;
      m_ack_q    <= m_ack_d;
      m_rdata_q  <= m_rdata_d;
`ifndef MEM_ARB_FIXED_PRI_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign m_ack       = m_ack_q;
  assign m_rdata     = m_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_do      = mem_do_q;
  assign mem_we      = mem_we_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses RD_LAT=1, instance b uses RD_LAT=3.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [63:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [7:0]  a_rdata, b_rdata, a_mem_do, b_mem_do, a_mem_di, b_mem_di;
  logic [15:0] a_mem_addr, b_mem_addr;
  logic        a_mem_we, b_mem_we, a_busy, b_busy;
  logic [1:0]  a_dbg, b_dbg;

  logic [7:0]  ram_a [0:255];
  logic [7:0]  ram_b [0:255];
  logic [7:0]  b_p1, b_p2;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CH(4), .AW(16), .DW(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .m_req(a_req), .m_we(a_we), .m_addr(a_addr), .m_wdata(a_wdata),
    .m_ack(a_ack), .m_rdata(a_rdata), .mem_addr(a_mem_addr), .mem_do(a_mem_do),
    .mem_we(a_mem_we), .mem_di(a_mem_di), .busy(a_busy), .dbg_state_o(a_dbg)
  );

  mem_arbiter #(.NUM_CH(4), .AW(16), .DW(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .m_req(b_req), .m_we(b_we), .m_addr(b_addr), .m_wdata(b_wdata),
    .m_ack(b_ack), .m_rdata(b_rdata), .mem_addr(b_mem_addr), .mem_do(b_mem_do),
    .mem_we(b_mem_we), .mem_di(b_mem_di), .busy(b_busy), .dbg_state_o(b_dbg)
  );

  // RAM models: a reads combinationally (latency 1), b through two output stages (latency 3).
  always @(posedge clk) begin
    if (a_mem_we) ram_a[a_mem_addr[7:0]] <= a_mem_do;
    if (b_mem_we) ram_b[b_mem_addr[7:0]] <= b_mem_do;
    b_p1 <= ram_b[b_mem_addr[7:0]];
    b_p2 <= b_p1;
  end
  assign a_mem_di = ram_a[a_mem_addr[7:0]];
  assign b_mem_di = b_p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ack_of(input bit on_b);
    return on_b ? 32'(b_ack) : 32'(a_ack);
  endfunction
  function automatic logic [31:0] rdata_of(input bit on_b);
    return on_b ? 32'(b_rdata) : 32'(a_rdata);
  endfunction
  function automatic logic [31:0] we_of(input bit on_b);
    return on_b ? 32'(b_mem_we) : 32'(a_mem_we);
  endfunction
  function automatic logic [31:0] addr_of(input bit on_b);
    return on_b ? 32'(b_mem_addr) : 32'(a_mem_addr);
  endfunction
  function automatic logic [31:0] busy_of(input bit on_b);
    return on_b ? 32'(b_busy) : 32'(a_busy);
  endfunction

  task automatic drive(input bit on_b, input int ch, input bit we, input logic [15:0] addr,
                       input logic [7:0] wd);
    if (on_b) begin
      b_we[ch] = we; b_addr[ch*16 +: 16] = addr; b_wdata[ch*8 +: 8] = wd; b_req[ch] = 1'b1;
    end else begin
      a_we[ch] = we; a_addr[ch*16 +: 16] = addr; a_wdata[ch*8 +: 8] = wd; a_req[ch] = 1'b1;
    end
  endtask

  task automatic drop(input bit on_b, input int ch);
    if (on_b) b_req[ch] = 1'b0;
    else a_req[ch] = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE three cycles after the ack.
  task automatic txn(input bit on_b, input int ch, input bit we, input logic [15:0] addr,
                     input logic [7:0] wd, input logic [7:0] exp_rd, input bit drop_early,
                     input string tag);
    int lat;
    lat = we ? 2 : (on_b ? 4 : 2);
    drive(on_b, ch, we, addr, wd);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      check({tag, "_busy"}, busy_of(on_b), 32'd1);
      check({tag, "_mem_we"}, we_of(on_b), (c == 1) ? 32'(we) : 32'd0);
      check({tag, "_mem_addr"}, addr_of(on_b), 32'(addr));
      check({tag, "_early_ack"}, ack_of(on_b), 32'd0);
      if (drop_early && c == 2) drop(on_b, ch);
    end
    @(negedge clk);
    check({tag, "_ack"}, ack_of(on_b), 32'(1 << ch));
    check({tag, "_rdata"}, rdata_of(on_b), 32'(exp_rd));
    check({tag, "_done_we"}, we_of(on_b), 32'd0);
    drop(on_b, ch);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check({tag, "_idle_ack"}, ack_of(on_b), 32'd0);
      check({tag, "_idle_busy"}, busy_of(on_b), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [3:0] exp_ack;
    rst = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(a_ack), 32'd0);
    check("rst_rdata", 32'(a_rdata), 32'd0);
    check("rst_mem_addr", 32'(a_mem_addr), 32'd0);
    check("rst_mem_do", 32'(a_mem_do), 32'd0);
    check("rst_mem_we", 32'(a_mem_we), 32'd0);
    check("rst_busy", 32'(a_busy | b_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write ch2 on RD_LAT=1 instance; rdata still holds its reset value.
    txn(1'b0, 2, 1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0, "a_wr");
    check("a_wr_ram", 32'(ram_a[8'h34]), 32'hA5);

    // Async reset while mem_we is high.
    drive(1'b0, 1, 1'b1, 16'h0010, 8'h3C);
    @(negedge clk);
    check("rstmid_we_before", 32'(a_mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_we", 32'(a_mem_we), 32'd0);
    check("rstmid_busy", 32'(a_busy), 32'd0);
    check("rstmid_addr", 32'(a_mem_addr), 32'd0);
    check("rstmid_do", 32'(a_mem_do), 32'd0);
    drop(1'b0, 1);
    @(negedge clk);
    check("rstmid_ack", 32'(a_ack), 32'd0);
    rst = 1'b0;

    // All four write at once; each drops after its ack, so the order is 0,1,2,3 in both modes.
    a_addr = {16'h0203, 16'h0202, 16'h0201, 16'h0200};
    a_wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    a_we = 4'hF;
    a_req = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_ack = (c % 3 == 2) ? 4'(1 << ((c - 2) / 3)) : 4'd0;
      check("allwr_ack", 32'(a_ack), 32'(exp_ack));
      check("allwr_mem_we", 32'(a_mem_we), (c % 3 == 1) ? 32'd1 : 32'd0);
      if (c % 3 == 1) check("allwr_mem_do", 32'(a_mem_do), 32'(8'h10 + (c - 1) / 3));
      a_req = a_req & ~exp_ack;
    end

    // All four hold read requests across five grants.
    a_we = 4'h0;
    a_req = 4'hF;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
`ifdef MEM_ARB_FIXED_PRI_EN
      k = 0;
`else
      k = ((c - 2) / 3) % 4;
`endif
      exp_ack = (c % 3 == 2) ? 4'(1 << k) : 4'd0;
      check("rr_ack", 32'(a_ack), 32'(exp_ack));
      check("rr_mem_we", 32'(a_mem_we), 32'd0);
      if (c % 3 == 2) check("rr_rdata", 32'(a_rdata), 32'(8'h10 + k));
      if (c == 14) a_req = 4'h0;
    end
    check("rr_end_busy", 32'(a_busy), 32'd0);

    // RD_LAT=3 instance: write, read, write holding rdata, dropped read.
    txn(1'b1, 0, 1'b1, 16'h1234, 8'h5A, 8'h00, 1'b0, "b_wr");
    txn(1'b1, 1, 1'b0, 16'h1234, 8'h00, 8'h5A, 1'b0, "b_rd");
    txn(1'b1, 2, 1'b1, 16'h0050, 8'h77, 8'h5A, 1'b0, "b_wr_hold");
    txn(1'b1, 3, 1'b0, 16'h0050, 8'h00, 8'h77, 1'b1, "b_drop");

    // Reset while waiting on a read: no ack, then a clean read from ch1.
    drive(1'b1, 1, 1'b0, 16'h1234, 8'h00);
    repeat (2) @(negedge clk);
    check("b_rstwait_busy_before", 32'(b_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("b_rstwait_busy", 32'(b_busy), 32'd0);
    check("b_rstwait_ack", 32'(b_ack), 32'd0);
    check("b_rstwait_rdata", 32'(b_rdata), 32'd0);
    drop(1'b1, 1);
    repeat (2) begin
      @(negedge clk);
      check("b_rstwait_hold_ack", 32'(b_ack), 32'd0);
    end
    rst = 1'b0;
    txn(1'b1, 1, 1'b0, 16'h1234, 8'h00, 8'h5A, 1'b0, "b_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
